// File: rtl/dpd_coef_bank_ctrl.sv
// Double-buffered DPD coefficient bank: writes land in the shadow bank, go live atomically on sync,
// and every swap or abort is followed by a live->shadow copy-back so new edits start from the live set.
module dpd_coef_bank_ctrl #(
  parameter int                  N_COEF    = 15,
  parameter int                  W         = 20,
  parameter int                  UNITY_IDX = 2,
  parameter logic signed [W-1:0] UNITY     = 20'sh40000,
  parameter int                  SYNC_TO   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_addr,
  input  logic [W-1:0]      wr_data_i,
  input  logic [W-1:0]      wr_data_q,
  input  logic              commit,
  input  logic              abort,
  input  logic              sync,
  output logic [N_COEF*W-1:0] coef_i,
  output logic [N_COEF*W-1:0] coef_q,
  output logic              bank_sel,
  output logic              busy,
  output logic              swap_done,
  output logic              timeout,
  output logic              addr_err
);

  localparam int IW = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam int CW = (SYNC_TO > 1) ? $clog2(SYNC_TO) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COPY  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            bank_sel_q, bank_sel_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [IW-1:0]   copy_idx_q, copy_idx_d;
  logic            swapped_q, swapped_d;
  logic            wr_ready_q, wr_ready_d;
  logic            busy_q, busy_d;
  logic            swap_done_q, swap_done_d;
  logic            timeout_q, timeout_d;
  logic            addr_err_q, addr_err_d;
  logic [W-1:0]    bank_i_q [2][N_COEF];
  logic [W-1:0]    bank_i_d [2][N_COEF];
  logic [W-1:0]    bank_q_q [2][N_COEF];
  logic [W-1:0]    bank_q_d [2][N_COEF];

  logic            wr_fire;
  logic            addr_ok;
  logic            live;
  logic            shadow;

  always_comb begin
    wr_fire     = wr_valid && wr_ready_q;
    addr_ok     = (32'(wr_addr) < 32'(N_COEF));
    live        = bank_sel_q;
    shadow      = ~bank_sel_q;

    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    wait_cnt_d  = wait_cnt_q;
    copy_idx_d  = copy_idx_q;
    swapped_d   = swapped_q;
    swap_done_d = 1'b0;
    timeout_d   = 1'b0;
    addr_err_d  = 1'b0;
    bank_i_d    = bank_i_q;
    bank_q_d    = bank_q_q;

    case (state_q)
      ST_IDLE: begin
        // A write in the same cycle as commit is part of the committed set.
        if (wr_fire) begin
          if (addr_ok) begin
            for (int k = 0; k < N_COEF; k++) begin
              if (wr_addr == 4'(k)) begin
                bank_i_d[shadow][k] = wr_data_i;
                bank_q_d[shadow][k] = wr_data_q;
              end
            end
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (abort) begin
          state_d    = ST_COPY;
          copy_idx_d = '0;
          swapped_d  = 1'b0;
        end else if (commit) begin
          state_d    = ST_ARMED;
          wait_cnt_d = '0;
        end
      end

      ST_ARMED: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        // sync outranks abort and timeout: the swap always happens on a sync edge.
        if (sync) begin
          bank_sel_d = ~bank_sel_q;
          state_d    = ST_COPY;
          copy_idx_d = '0;
          swapped_d  = 1'b1;
        end else if (abort) begin
          state_d    = ST_COPY;
          copy_idx_d = '0;
          swapped_d  = 1'b0;
        end else if ((SYNC_TO > 0) && (wait_cnt_q == CW'(SYNC_TO - 1))) begin
          timeout_d  = 1'b1;
          state_d    = ST_COPY;
          copy_idx_d = '0;
          swapped_d  = 1'b0;
        end
      end

      ST_COPY: begin
        for (int k = 0; k < N_COEF; k++) begin
          if (copy_idx_q == IW'(k)) begin
            bank_i_d[shadow][k] = bank_i_q[live][k];
            bank_q_d[shadow][k] = bank_q_q[live][k];
          end
        end
        if (copy_idx_q == IW'(N_COEF - 1)) begin
          state_d     = ST_IDLE;
          swap_done_d = swapped_q;
          swapped_d   = 1'b0;
        end else begin
          copy_idx_d = copy_idx_q + IW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wr_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bank_sel_q  <= 1'b0;
      wait_cnt_q  <= '0;
      copy_idx_q  <= '0;
      swapped_q   <= 1'b0;
      wr_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      swap_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N_COEF; k++) begin
          bank_i_q[b][k] <= (k == UNITY_IDX) ? UNITY : '0;
          bank_q_q[b][k] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      wait_cnt_q  <= wait_cnt_d;
      copy_idx_q  <= copy_idx_d;
      swapped_q   <= swapped_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      swap_done_q <= swap_done_d;
      timeout_q   <= timeout_d;
      addr_err_q  <= addr_err_d;
      bank_i_q    <= bank_i_d;
      bank_q_q    <= bank_q_d;
    end
  end

  // Live outputs are a plain mux so every coefficient flips on the swap edge itself.
  always_comb begin
    coef_i = '0;
    coef_q = '0;
    for (int k = 0; k < N_COEF; k++) begin
      coef_i[k*W +: W] = bank_i_q[bank_sel_q][k];
      coef_q[k*W +: W] = bank_q_q[bank_sel_q][k];
    end
  end

  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign swap_done = swap_done_q;
  assign timeout   = timeout_q;
  assign addr_err  = addr_err_q;
  assign bank_sel  = bank_sel_q;

endmodule
